// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type and arithmetic helpers for the systolic matrix-multiply engine
//   state_t         engine FSM states
//   flush_len()     cycles for the last slice to reach the far corner PE
//   extend_product  sign/zero extension of a raw product from a given width
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
    localparam int EXT_W = 128;
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction
    function automatic logic [EXT_W-1:0] extend_product(input logic [EXT_W-1:0] prod, input int width,
                                                        input bit is_signed);
        logic [EXT_W-1:0] hi;
        hi = {EXT_W{1'b1}} << width;
        return (is_signed && prod[width-1]) ? (prod | hi) : (prod & ~hi);
    endfunction
endpackage

// File: rtl/systolic_mm_engine_pe.sv
// pe_mac: one output-stationary processing element
//   a, b          operands arriving from the left / above
//   a_fwd, b_fwd  operands registered onward to the right / below
//   acc_clr       zeroes the accumulator on this edge
//   acc           running wrapped sum of a*b
module pe_mac
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ACC_WIDTH = 38,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_clr,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] a_fwd,
    output logic [DATAWIDTH-1:0] b_fwd,
    output logic [ACC_WIDTH-1:0] acc
);
    logic [2*DATAWIDTH-1:0] a_x, b_x, prod;
    logic [ACC_WIDTH-1:0]   prod_ext;
    // Operands are pre-extended to the product width so the low half of an
    // ordinary multiply is the correct signed or unsigned product.
    assign a_x      = {{DATAWIDTH{SIGNED != 0 && a[DATAWIDTH-1]}}, a};
    assign b_x      = {{DATAWIDTH{SIGNED != 0 && b[DATAWIDTH-1]}}, b};
    assign prod     = a_x * b_x;
    assign prod_ext = ACC_WIDTH'(extend_product(EXT_W'(prod), 2 * DATAWIDTH, SIGNED != 0));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_fwd <= '0;
            b_fwd <= '0;
            acc   <= '0;
        end else begin
            a_fwd <= a;
            b_fwd <= b;
            acc   <= acc_clr ? '0 : acc + prod_ext;
        end
    end
endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: self-sequencing output-stationary C = A*B engine with internal skewing
//   in_valid/in_ready/in_last, a_vec, b_vec   one k-slice (A column k, B row k) per handshake
//   out_valid/out_ready, out_row, out_row_idx, out_last   C streamed one row per handshake
//   busy            engine not idle
//   err_k_overflow  sticky: job hit K_MAX slices without in_last
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 64,
    parameter int ACC_WIDTH = 2 * DATAWIDTH + $clog2(K_MAX),
    parameter int SIGNED    = 1,
    localparam int RIW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [ROWS*DATAWIDTH-1:0] a_vec,
    input  logic [COLS*DATAWIDTH-1:0] b_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_WIDTH-1:0] out_row,
    output logic [RIW-1:0]            out_row_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_k_overflow
);
    localparam int F  = flush_len(ROWS, COLS);
    localparam int FW = $clog2(F + 1);
    localparam int KW = $clog2(K_MAX + 1);

    state_t         state, state_n;
    logic [FW-1:0]  fcnt;
    logic [KW-1:0]  k_cnt, k_cur;
    logic [RIW-1:0] row_idx;
    logic           fire, at_kmax, slice_last, out_fire, acc_clr;

    logic [DATAWIDTH-1:0] a_h [ROWS][COLS+1];
    logic [DATAWIDTH-1:0] b_v [ROWS+1][COLS];
    logic [ACC_WIDTH-1:0] acc [ROWS][COLS];

    assign in_ready    = state == IDLE || state == LOAD;
    assign out_valid   = state == DRAIN;
    assign busy        = state != IDLE;
    assign out_row_idx = row_idx;
    assign out_last    = out_valid && row_idx == RIW'(ROWS - 1);
    assign fire        = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign acc_clr     = out_fire && out_last;
    // The count of the current job restarts implicitly when leaving IDLE.
    assign k_cur       = state == IDLE ? '0 : k_cnt;
    assign at_kmax     = k_cur == KW'(K_MAX - 1);
    assign slice_last  = in_last || at_kmax;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, LOAD: state_n = fire ? (slice_last ? FLUSH : LOAD) : state;
            FLUSH:      state_n = fcnt == '0 ? DRAIN : FLUSH;
            DRAIN:      state_n = acc_clr ? IDLE : DRAIN;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            fcnt           <= '0;
            k_cnt          <= '0;
            row_idx        <= '0;
            err_k_overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (fire)
                k_cnt <= k_cur + 1'b1;
            // First slice of a job clears the flag; the K_MAX-th slice may set it.
            if (fire && (state == IDLE || at_kmax))
                err_k_overflow <= at_kmax && !in_last;
            if (fire && slice_last)
                fcnt <= FW'(F - 1);
            else if (state == FLUSH && fcnt != '0)
                fcnt <= fcnt - 1'b1;
            if (out_fire)
                row_idx <= out_last ? '0 : row_idx + 1'b1;
        end
    end

    // Row i of A gets one capture register plus i skew registers; zeros are
    // injected whenever no slice is accepted, so idle cycles add nothing.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DATAWIDTH-1:0] stage [i+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) stage[s] <= '0;
            end else begin
                stage[0] <= fire ? a_vec[i*DATAWIDTH +: DATAWIDTH] : '0;
                for (int s = 1; s <= i; s++) stage[s] <= stage[s-1];
            end
        end
        assign a_h[i][0] = stage[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [DATAWIDTH-1:0] stage [j+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= j; s++) stage[s] <= '0;
            end else begin
                stage[0] <= fire ? b_vec[j*DATAWIDTH +: DATAWIDTH] : '0;
                for (int s = 1; s <= j; s++) stage[s] <= stage[s-1];
            end
        end
        assign b_v[0][j] = stage[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            pe_mac #(
                .DATAWIDTH(DATAWIDTH),
                .ACC_WIDTH(ACC_WIDTH),
                .SIGNED   (SIGNED)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .acc_clr(acc_clr),
                .a      (a_h[i][j]),
                .b      (b_v[i][j]),
                .a_fwd  (a_h[i][j+1]),
                .b_fwd  (b_v[i+1][j]),
                .acc    (acc[i][j])
            );
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_out
        assign out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][j];
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: signed and unsigned engines run in lockstep against a plain matrix-product model
module tb_systolic_mm_engine;
    localparam int DW = 16, R = 4, C = 4, KM = 4, AW = 2 * DW + 2, NK = 6;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [R*DW-1:0] a_vec = '0;
    logic [C*DW-1:0] b_vec = '0;
    logic in_ready_s, out_valid_s, out_last_s, busy_s, err_s;
    logic in_ready_u, out_valid_u, out_last_u, busy_u, err_u;
    logic [C*AW-1:0] row_s, row_u;
    logic [1:0] idx_s, idx_u;

    int cyc = 0, checks = 0, fails = 0, acc_cyc = 0;
    logic [DW-1:0] am [R][NK];
    logic [DW-1:0] bm [NK][C];
    logic [C*AW-1:0] got_s [R];
    logic [C*AW-1:0] got_u [R];
    logic [1:0] gidx [R];
    logic glast [R];
    bit hold_ok;

    systolic_mm_engine #(.DATAWIDTH(DW), .ROWS(R), .COLS(C), .K_MAX(KM), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_row(row_s), .out_row_idx(idx_s), .out_last(out_last_s), .busy(busy_s),
        .err_k_overflow(err_s));

    systolic_mm_engine #(.DATAWIDTH(DW), .ROWS(R), .COLS(C), .K_MAX(KM), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_last(in_last),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_row(row_u), .out_row_idx(idx_u), .out_last(out_last_u), .busy(busy_u),
        .err_k_overflow(err_u));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] model(input int r, input int c, input int k, input bit sg);
        longint sum = 0;
        for (int t = 0; t < k; t++)
            sum += sg ? longint'($signed(am[r][t])) * longint'($signed(bm[t][c]))
                      : longint'(am[r][t]) * longint'(bm[t][c]);
        return AW'(sum);
    endfunction

    task automatic rand_data();
        for (int i = 0; i < R; i++) for (int s = 0; s < NK; s++) am[i][s] = DW'($urandom);
        for (int s = 0; s < NK; s++) for (int j = 0; j < C; j++) bm[s][j] = DW'($urandom);
    endtask

    task automatic put_slice(input int s, input bit last);
        for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = am[i][s];
        for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = bm[s][j];
        in_valid = 1;
        in_last  = last;
    endtask

    task automatic feed_job(input int k, input bit stall, output bit rdy);
        rdy = 1;
        for (int s = 0; s < k; s++) begin
            if (stall && s > 0) begin
                in_valid = 0;
                a_vec = (R*DW)'({$urandom, $urandom});
                rdy &= in_ready_s && in_ready_u;
                @(negedge clk);
            end
            put_slice(s, s == k - 1);
            rdy &= in_ready_s && in_ready_u;
            @(negedge clk);
        end
        in_valid = 0;
        in_last  = 0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_valid(output int lat);
        int w = 0;
        while (!out_valid_s && w < 50) begin
            @(negedge clk);
            w++;
        end
        lat = out_valid_s ? cyc - acc_cyc : -1;
    endtask

    task automatic drain(input logic [3:0] pat, output bit to);
        int n = 0, w = 0, p = 0;
        logic [C*AW-1:0] prev_row;
        logic [1:0] prev_idx;
        bit held = 0;
        hold_ok = 1;
        while (n < R && w < 200) begin
            if (out_valid_s) begin
                if (held && (row_s !== prev_row || idx_s !== prev_idx)) hold_ok = 0;
                out_ready = pat[p%4];
                p++;
                if (out_ready) begin
                    got_s[n] = row_s;
                    got_u[n] = row_u;
                    gidx[n]  = idx_s;
                    glast[n] = out_last_s;
                    n++;
                    held = 0;
                end else begin
                    prev_row = row_s;
                    prev_idx = idx_s;
                    held = 1;
                end
            end else out_ready = 0;
            @(negedge clk);
            w++;
        end
        out_ready = 0;
        to = n < R;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready_s, in_ready_u, out_valid_s, busy_s, err_s, out_last_s, idx_s} !== 8'b11_0000_00) begin
            fails++;
            $display("FAIL reset_flags got %b want 11000000",
                     {in_ready_s, in_ready_u, out_valid_s, busy_s, err_s, out_last_s, idx_s});
        end
        checks++;
        if (row_s !== '0 || row_u !== '0) begin
            fails++;
            $display("FAIL reset_row got %h/%h want 0", row_s, row_u);
        end
        rst = 0;
    endtask

    task automatic test_identity(input bit stall);
        bit rdy, to;
        int lat;
        for (int i = 0; i < R; i++) for (int s = 0; s < NK; s++) am[i][s] = DW'(i == s);
        for (int s = 0; s < NK; s++) for (int j = 0; j < C; j++) bm[s][j] = DW'(4 * s + j + 1);
        feed_job(4, stall, rdy);
        checks++;
        if (!rdy) begin fails++; $display("FAIL ident_in_ready stall=%0d got 0 want 1", stall); end
        wait_valid(lat);
        checks++;
        if (lat != 7 || out_valid_u !== 1'b1) begin
            fails++;
            $display("FAIL ident_latency got %0d (u valid %b) want 7", lat, out_valid_u);
        end
        drain(4'b1111, to);
        checks++;
        if (to) begin fails++; $display("FAIL ident_drain_timeout got timeout want 4 rows"); end
        for (int r = 0; r < R; r++) begin
            checks++;
            if (gidx[r] !== 2'(r) || glast[r] !== (r == R - 1)) begin
                fails++;
                $display("FAIL ident_order r%0d got idx %0d last %b", r, gidx[r], glast[r]);
            end
            for (int j = 0; j < C; j++) begin
                checks++;
                if (got_s[r][j*AW +: AW] !== AW'(4 * r + j + 1) || got_u[r][j*AW +: AW] !== AW'(4 * r + j + 1)) begin
                    fails++;
                    $display("FAIL ident_c r%0d c%0d got %h/%h want %h", r, j,
                             got_s[r][j*AW +: AW], got_u[r][j*AW +: AW], 4 * r + j + 1);
                end
            end
        end
    endtask

    task automatic test_arith(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int k,
                              input logic [AW-1:0] want_s, input logic [AW-1:0] want_u);
        bit rdy, to;
        int lat;
        for (int i = 0; i < R; i++) for (int s = 0; s < NK; s++) am[i][s] = av;
        for (int s = 0; s < NK; s++) for (int j = 0; j < C; j++) bm[s][j] = bv;
        feed_job(k, 0, rdy);
        wait_valid(lat);
        drain(4'b1111, to);
        checks++;
        if (to || lat != 7) begin fails++; $display("FAIL arith_timing got lat %0d to %b want 7 0", lat, to); end
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) begin
            checks++;
            if (got_s[r][j*AW +: AW] !== want_s || got_u[r][j*AW +: AW] !== want_u) begin
                fails++;
                $display("FAIL arith r%0d c%0d got %h/%h want %h/%h", r, j,
                         got_s[r][j*AW +: AW], got_u[r][j*AW +: AW], want_s, want_u);
            end
        end
    endtask

    task automatic test_random_job(input string name, input int k, input bit stall, input logic [3:0] pat);
        bit rdy, to;
        int lat;
        rand_data();
        feed_job(k, stall, rdy);
        wait_valid(lat);
        drain(pat, to);
        checks++;
        if (!rdy || to || lat != 7 || !hold_ok) begin
            fails++;
            $display("FAIL %s_flow got rdy %b to %b lat %0d hold %b want 1 0 7 1", name, rdy, to, lat, hold_ok);
        end
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) begin
            checks++;
            if (gidx[r] !== 2'(r) || got_s[r][j*AW +: AW] !== model(r, j, k, 1) ||
                got_u[r][j*AW +: AW] !== model(r, j, k, 0)) begin
                fails++;
                $display("FAIL %s_c r%0d c%0d idx %0d got %h/%h want %h/%h", name, r, j, gidx[r],
                         got_s[r][j*AW +: AW], got_u[r][j*AW +: AW], model(r, j, k, 1), model(r, j, k, 0));
            end
        end
    endtask

    task automatic test_k_overflow();
        int n_acc = 0, lat;
        bit take, to, rdy;
        rand_data();
        for (int s = 0; s < NK; s++) begin
            put_slice(s, 0);
            take = in_ready_s;
            @(negedge clk);
            if (take) begin
                n_acc++;
                if (n_acc == KM) acc_cyc = cyc;
            end
        end
        in_valid = 0;
        checks++;
        if (n_acc != KM || in_ready_s !== 1'b0 || err_s !== 1'b1 || err_u !== 1'b1) begin
            fails++;
            $display("FAIL kovf_state got acc %0d rdy %b err %b/%b want 4 0 1 1", n_acc, in_ready_s, err_s, err_u);
        end
        wait_valid(lat);
        drain(4'b1111, to);
        checks++;
        if (to || lat != 7 || err_s !== 1'b1) begin
            fails++;
            $display("FAIL kovf_flow got lat %0d to %b err %b want 7 0 1", lat, to, err_s);
        end
        for (int r = 0; r < R; r++) for (int j = 0; j < C; j++) begin
            checks++;
            if (got_s[r][j*AW +: AW] !== model(r, j, KM, 1) || got_u[r][j*AW +: AW] !== model(r, j, KM, 0)) begin
                fails++;
                $display("FAIL kovf_c r%0d c%0d got %h/%h want %h/%h", r, j, got_s[r][j*AW +: AW],
                         got_u[r][j*AW +: AW], model(r, j, KM, 1), model(r, j, KM, 0));
            end
        end
        rand_data();
        feed_job(2, 0, rdy);
        checks++;
        if (err_s !== 1'b0 || err_u !== 1'b0) begin
            fails++;
            $display("FAIL kovf_clear got %b/%b want 0", err_s, err_u);
        end
        wait_valid(lat);
        drain(4'b1111, to);
    endtask

    task automatic test_reset_flush();
        bit rdy;
        rand_data();
        feed_job(3, 0, rdy);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_s !== 1'b1 || in_ready_s !== 1'b0) begin
            fails++;
            $display("FAIL rstf_pre got busy %b rdy %b want 1 0", busy_s, in_ready_s);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({in_ready_s, in_ready_u, busy_s, out_valid_s, err_s} !== 5'b11000 || row_s !== '0 || row_u !== '0) begin
            fails++;
            $display("FAIL rstf_async got %b row %h want 11000 row 0",
                     {in_ready_s, in_ready_u, busy_s, out_valid_s, err_s}, row_s);
        end
        @(negedge clk);
        rst = 0;
        test_random_job("rstf_fresh", 4, 0, 4'b1111);
    endtask

    initial begin
        test_reset();
        test_identity(0);
        test_identity(1);
        test_arith(16'hFFFD, 16'd5, 4, AW'(-60), AW'(34'h13FFC4));
        test_arith(16'hFFFF, 16'd2, 1, AW'(-2), AW'(34'h1FFFE));
        test_random_job("hold", 3, 0, 4'b1001);
        test_random_job("b2b", 2, 0, 4'b1111);
        test_k_overflow();
        test_reset_flush();
        for (int n = 0; n < 6; n++)
            test_random_job("rand", int'($urandom_range(1, KM)), 1'($urandom), 4'($urandom) | 4'b0001);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule
